single_rx_uart: RTL
===================

// Module: single_rx_uart
// PURPOSE
//  Receives one UART character at a time from the rxd pin and presents the byte to
//  fabric with a one-cycle valid strobe plus parity and framing error flags.
//  Receive-side counterpart of the single-byte UART transmitter, with the same
//  parameter set and frame format. Sits between the board pin and command/FIFO logic.
// PARAMETERS
//  CLOCK      10_000_000  clk frequency, Hz
//  BAUD       1_000_000   line rate, bit/s; FACTOR = CLOCK/BAUD (integer div), FACTOR >= 4
//  PARITY     "NO"        "NO" | "EVEN" | "ODD"; EVEN: bit = ^data, ODD: bit = ~^data
//  FIRST_BIT  "LSB"       "LSB": first data bit on line -> rx_data[0]; "MSB": -> rx_data[7]
// PORTS
//  clk         in   1  system clock
//  reset       in   1  asynchronous, active-high reset
//  rxd         in   1  serial line, asynchronous to clk, idle high
//  rx_data     out  8  last received byte, held until next rx_valid
//  rx_valid    out  1  one-cycle strobe: rx_data/parity_err/frame_err updated
//  parity_err  out  1  parity mismatch on last frame; always 0 when PARITY="NO"
//  frame_err   out  1  stop bit sampled low on last frame
//  busy        out  1  frame reception in progress (START..STOP states)
// BEHAVIOUR
//  - Reset: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, busy=0, FSM=IDLE,
//    both rxd synchronizer flops=1. Reset mid-frame aborts the frame; no strobe.
//  - rxd passes through a 2-flop synchronizer -> rxd_s; all logic uses rxd_s only.
//  - N = 10 (PARITY="NO") or 11 (parity); frame = start, 8 data, [parity], stop.
//  - HALF = FACTOR/2. t0 = first cycle rxd_s==0 while in IDLE. Bit k (k=0 start)
//    is sampled at cycle t0+HALF+k*FACTOR by a bit-length counter, width clog2(FACTOR).
//  - FSM: IDLE -> START on rxd_s==0. START: at sample, rxd_s==1 -> IDLE (glitch
//    rejected, no strobe); else -> DATA. DATA: 8 samples shifted per FIRST_BIT,
//    then -> PARITY (if enabled) or STOP. PARITY: 1 sample, compare -> STOP.
//    STOP: 1 sample; rx_valid=1 on cycle t0+HALF+(N-1)*FACTOR+1 (registered).
//    After STOP: rxd_s==1 -> IDLE; rxd_s==0 (break) -> WAIT_HIGH until rxd_s==1 -> IDLE.
//  - busy=1 from cycle t0+1 through the stop-sample cycle; 0 in IDLE and WAIT_HIGH.
//  - Strobe is issued for every frame passing START check, even with errors; rx_data,
//    parity_err, frame_err update only with rx_valid and hold otherwise.
//  - Back-to-back frames (next start edge right after stop bit) must be received;
//    STOP returns to IDLE mid-stop-bit so the next falling edge is not missed.
//  - No overrun handling: consumer must take rx_data before the next rx_valid.
// TESTING  (CLOCK=10_000_000, BAUD=1_000_000 -> FACTOR=10, HALF=5)
//  1. PARITY="NO", LSB, send 0xA5 -> one rx_valid at t0+96, rx_data=8'hA5, errs=0.
//  2. FIRST_BIT="MSB", send line bits 1,0,1,0,0,1,0,1 -> rx_data=8'hA5, no errors.
//  3. PARITY="EVEN", 0x3C with parity 0 -> parity_err=0; parity 1 -> parity_err=1,
//     rx_data=8'h3C; repeat ODD: parity 1 ok, parity 0 -> parity_err=1.
//  4. rxd low 3 clk then high -> busy pulses, no rx_valid, next 0x55 frame received.
//  5. Stop bit low, rxd held low 50 clk -> rx_valid, frame_err=1; no new frame until
//     rxd high; following 0x0F frame -> rx_data=8'h0F, frame_err=0.
//  6. Reset at bit 4 of a frame -> all outputs 0 at once, no strobe; next 0xC3 -> ok;
//     plus 3 back-to-back frames 0x01,0x80,0xFF with zero idle -> 3 correct strobes.

Source files
------------

// File: rtl/single_rx_uart.sv
// Single-character UART receiver: synchronizes rxd, samples mid-bit and strobes
// each received byte with parity and framing error flags.
module single_rx_uart #(
  parameter int unsigned CLOCK     = 10_000_000,
  parameter int unsigned BAUD      = 1_000_000,
  parameter string       PARITY    = "NO",
  parameter string       FIRST_BIT = "LSB"
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned FACTOR    = CLOCK / BAUD;
  localparam int unsigned HALF      = FACTOR / 2;
  localparam int unsigned CNT_W     = $clog2(FACTOR);
  localparam bit          PAR_EN    = (PARITY == "EVEN") || (PARITY == "ODD");
  localparam bit          PAR_ODD   = (PARITY == "ODD");
  localparam bit          MSB_FIRST = (FIRST_BIT == "MSB");

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic             rxd_m;
  logic             rxd_s;
  state_t           state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [2:0]       bit_q,      bit_d;
  logic [7:0]       shreg_q,    shreg_d;
  logic             perr_q,     perr_d;
  logic [7:0]       rx_data_d;
  logic             rx_valid_d;
  logic             parity_err_d;
  logic             frame_err_d;
  logic             busy_d;
  logic             tick;
  logic             exp_par;

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      perr_q     <= perr_d;
      rx_data    <= rx_data_d;
      rx_valid   <= rx_valid_d;
      parity_err <= parity_err_d;
      frame_err  <= frame_err_d;
      busy       <= busy_d;
    end
  end

  // Down-counter hits zero on each mid-bit sample point
  assign tick    = (cnt_q == '0);
  assign exp_par = PAR_ODD ? ~(^shreg_q) : ^shreg_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    perr_d       = perr_q;
    rx_data_d    = rx_data;
    rx_valid_d   = 1'b0;
    parity_err_d = parity_err;
    frame_err_d  = frame_err;

    case (state_q)
      S_IDLE: begin
        if (!rxd_s) begin
          state_d = S_START;
          cnt_d   = CNT_W'(HALF - 1);
          bit_d   = '0;
          perr_d  = 1'b0;
        end
      end

      S_START: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rxd_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DATA;
          cnt_d   = CNT_W'(FACTOR - 1);
        end
      end

      S_DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          shreg_d = MSB_FIRST ? {shreg_q[6:0], rxd_s} : {rxd_s, shreg_q[7:1]};
          cnt_d   = CNT_W'(FACTOR - 1);
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = PAR_EN ? S_PARITY : S_STOP;
          end
        end
      end

      S_PARITY: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          perr_d  = (rxd_s != exp_par);
          cnt_d   = CNT_W'(FACTOR - 1);
          state_d = S_STOP;
        end
      end

      // Leave mid-stop-bit so a back-to-back start edge is still caught
      S_STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rx_valid_d   = 1'b1;
          rx_data_d    = shreg_q;
          parity_err_d = PAR_EN ? perr_q : 1'b0;
          frame_err_d  = !rxd_s;
          state_d      = rxd_s ? S_IDLE : S_WAIT_HIGH;
        end
      end

      S_WAIT_HIGH: begin
        if (rxd_s) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_START) || (state_d == S_DATA) ||
             (state_d == S_PARITY) || (state_d == S_STOP);
  end

endmodule
